// File: rtl/wasm_fetch_if.sv
// Bus bundle for the wasm fetch unit: loader control, byte memory, call/jump/fetch channels.
interface wasm_fetch_if;
  logic        enable;
  logic [31:0] start_pc;

  logic [31:0] mem_addr;
  logic        mem_read_en;
  logic        mem_ready;
  logic [7:0]  mem_data_out;

  logic        call_valid;
  logic [7:0]  call_func_id;
  logic        call_ready;
  logic        call_done;
  logic [31:0] fn_addr;
  logic [5:0]  fn_argc;
  logic        fn_is_import;
  logic        fn_is_service;

  logic        jump_valid;
  logic [31:0] jump_addr;

  logic        req_valid;
  logic [1:0]  req_kind;
  logic        req_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [31:0] resp_pc;
  logic        resp_err;

  logic [31:0] pc;

  // Fetch unit side
  modport slave (
    input  enable, start_pc,
    output mem_addr, mem_read_en,
    input  mem_ready, mem_data_out,
    input  call_valid, call_func_id,
    output call_ready, call_done, fn_addr, fn_argc, fn_is_import, fn_is_service,
    input  jump_valid, jump_addr,
    input  req_valid, req_kind,
    output req_ready, resp_valid,
    input  resp_ready,
    output resp_data, resp_pc, resp_err,
    output pc
  );

  // Environment side: loader, memory and execute stage
  modport master (
    output enable, start_pc,
    input  mem_addr, mem_read_en,
    output mem_ready, mem_data_out,
    output call_valid, call_func_id,
    input  call_ready, call_done, fn_addr, fn_argc, fn_is_import, fn_is_service,
    output jump_valid, jump_addr,
    output req_valid, req_kind,
    input  req_ready, resp_valid,
    output resp_ready,
    input  resp_data, resp_pc, resp_err,
    input  pc
  );
endinterface

// File: rtl/wasm_fetch.sv
// Fetch unit: resolves function-table entries to code addresses and fetches
// opcode bytes and LEB128 immediates from byte-wide memory at a local PC.
module wasm_fetch #(
  parameter logic [31:0] FTAB_BASE     = 32'h0000_0000,
  parameter int unsigned ENTRY_BYTES   = 5,
  parameter int unsigned MAX_LEB_BYTES = 5
) (
  input logic        clk,
  input logic        rst_n,
  wasm_fetch_if.slave bus
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned SH_W  = 7;
  localparam logic [1:0]  K_ULEB = 2'd1;
  localparam logic [1:0]  K_SLEB = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_TBL, S_FETCH, S_RESP} state_e;

  state_e           state_q, state_d;
  logic             started_q, started_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic             mem_read_en_q, mem_read_en_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      acc_q, acc_d;
  logic [1:0]       kind_q, kind_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [31:0]      resp_pc_q, resp_pc_d;
  logic             resp_err_q, resp_err_d;
  logic             call_done_q, call_done_d;
  logic [31:0]      fn_addr_q, fn_addr_d;
  logic [5:0]       fn_argc_q, fn_argc_d;
  logic             fn_is_import_q, fn_is_import_d;
  logic             fn_is_service_q, fn_is_service_d;

  logic             can_accept, call_acc, jump_acc, req_acc;
  logic             mem_hit;
  logic [7:0]       rd_byte;
  logic [SH_W-1:0]  leb_sh, leb_n_sh;
  logic [31:0]      leb_byte, leb_acc, sext_mask;
  logic             leb_last, is_leb;

  // Accept arbitration: call beats jump beats fetch request
  assign can_accept = (state_q == S_IDLE) && bus.enable && started_q;
  assign call_acc   = can_accept && bus.call_valid;
  assign jump_acc   = can_accept && !bus.call_valid && bus.jump_valid;
  assign req_acc    = can_accept && !bus.call_valid && !bus.jump_valid && bus.req_valid;

  // LEB128 decode helpers for the byte arriving this cycle
  assign mem_hit   = mem_read_en_q && bus.mem_ready;
  assign rd_byte   = bus.mem_data_out;
  assign leb_sh    = SH_W'(cnt_q) * SH_W'(7);
  assign leb_n_sh  = leb_sh + SH_W'(7);
  assign leb_byte  = 32'(rd_byte[6:0]) << leb_sh;
  assign leb_acc   = acc_q | leb_byte;
  assign sext_mask = (leb_n_sh < SH_W'(32)) ? (32'hFFFF_FFFF << leb_n_sh) : 32'h0;
  assign leb_last  = !rd_byte[7] || (cnt_q == CNT_W'(MAX_LEB_BYTES - 1));
  assign is_leb    = (kind_q == K_ULEB) || (kind_q == K_SLEB);

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      started_q       <= 1'b0;
      pc_q            <= 32'h0;
      mem_addr_q      <= 32'h0;
      mem_read_en_q   <= 1'b0;
      cnt_q           <= '0;
      acc_q           <= 32'h0;
      kind_q          <= 2'd0;
      resp_valid_q    <= 1'b0;
      resp_data_q     <= 32'h0;
      resp_pc_q       <= 32'h0;
      resp_err_q      <= 1'b0;
      call_done_q     <= 1'b0;
      fn_addr_q       <= 32'h0;
      fn_argc_q       <= 6'd0;
      fn_is_import_q  <= 1'b0;
      fn_is_service_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      started_q       <= started_d;
      pc_q            <= pc_d;
      mem_addr_q      <= mem_addr_d;
      mem_read_en_q   <= mem_read_en_d;
      cnt_q           <= cnt_d;
      acc_q           <= acc_d;
      kind_q          <= kind_d;
      resp_valid_q    <= resp_valid_d;
      resp_data_q     <= resp_data_d;
      resp_pc_q       <= resp_pc_d;
      resp_err_q      <= resp_err_d;
      call_done_q     <= call_done_d;
      fn_addr_q       <= fn_addr_d;
      fn_argc_q       <= fn_argc_d;
      fn_is_import_q  <= fn_is_import_d;
      fn_is_service_q <= fn_is_service_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d         = state_q;
    started_d       = started_q;
    pc_d            = pc_q;
    mem_addr_d      = mem_addr_q;
    mem_read_en_d   = mem_read_en_q;
    cnt_d           = cnt_q;
    acc_d           = acc_q;
    kind_d          = kind_q;
    resp_valid_d    = resp_valid_q;
    resp_data_d     = resp_data_q;
    resp_pc_d       = resp_pc_q;
    resp_err_d      = resp_err_q;
    call_done_d     = 1'b0;
    fn_addr_d       = fn_addr_q;
    fn_argc_d       = fn_argc_q;
    fn_is_import_d  = fn_is_import_q;
    fn_is_service_d = fn_is_service_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.enable && !started_q) begin
          // Loader just finished: adopt its first instruction address
          pc_d      = bus.start_pc;
          started_d = 1'b1;
        end else if (call_acc) begin
          state_d       = S_TBL;
          cnt_d         = '0;
          mem_addr_d    = FTAB_BASE + 32'(bus.call_func_id) * ENTRY_BYTES;
          mem_read_en_d = 1'b1;
        end else if (jump_acc) begin
          pc_d = bus.jump_addr;
        end else if (req_acc) begin
          state_d       = S_FETCH;
          kind_d        = bus.req_kind;
          cnt_d         = '0;
          acc_d         = 32'h0;
          resp_pc_d     = pc_q;
          mem_addr_d    = pc_q;
          mem_read_en_d = 1'b1;
        end
      end

      S_TBL: begin
        if (mem_hit) begin
          if (cnt_q == CNT_W'(ENTRY_BYTES - 1)) begin
            // Flags byte: publish the entry and branch to it
            fn_addr_d       = acc_q;
            fn_argc_d       = rd_byte[7:2];
            fn_is_import_d  = rd_byte[1];
            fn_is_service_d = rd_byte[0];
            pc_d            = acc_q;
            call_done_d     = 1'b1;
            mem_read_en_d   = 1'b0;
            state_d         = S_IDLE;
          end else begin
            // Address bytes arrive little-endian; shift in from the top
            acc_d      = {rd_byte, acc_q[31:8]};
            cnt_d      = cnt_q + CNT_W'(1);
            mem_addr_d = mem_addr_q + 32'd1;
          end
        end
      end

      S_FETCH: begin
        if (mem_hit) begin
          pc_d       = pc_q + 32'd1;
          mem_addr_d = pc_q + 32'd1;
          if (!is_leb) begin
            resp_data_d   = {24'h0, rd_byte};
            resp_err_d    = 1'b0;
            resp_valid_d  = 1'b1;
            mem_read_en_d = 1'b0;
            state_d       = S_RESP;
          end else if (leb_last) begin
            resp_data_d   = leb_acc |
                            (((kind_q == K_SLEB) && rd_byte[6]) ? sext_mask : 32'h0);
            resp_err_d    = rd_byte[7];
            resp_valid_d  = 1'b1;
            mem_read_en_d = 1'b0;
            state_d       = S_RESP;
          end else begin
            acc_d = leb_acc;
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end

      S_RESP: begin
        if (bus.resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.call_ready    = call_acc;
  assign bus.req_ready     = req_acc;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_read_en   = mem_read_en_q;
  assign bus.call_done     = call_done_q;
  assign bus.fn_addr       = fn_addr_q;
  assign bus.fn_argc       = fn_argc_q;
  assign bus.fn_is_import  = fn_is_import_q;
  assign bus.fn_is_service = fn_is_service_q;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.resp_pc       = resp_pc_q;
  assign bus.resp_err      = resp_err_q;
  assign bus.pc            = pc_q;

endmodule

// File: tb/tb_wasm_fetch.sv
// Testbench for wasm_fetch: vector table of byte/LEB fetches plus hand-written
// sequences for table lookup, arbitration, jump wrap, enable drop and reset.
module tb_wasm_fetch;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  wasm_fetch_if bus();

  wasm_fetch #(.FTAB_BASE(32'h0000_0010)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int checks   = 0;
  int failures = 0;

  logic [7:0] mem [logic [31:0]];
  bit         hold_mem = 1'b0;
  logic [31:0] tb_pc;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic        err;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [1:0]  kind;
    logic [47:0] bytes;
    int          nb;
    logic [31:0] data;
    logic        err;
    int          len;
  } vec_t;
  vec_t vecs[12];

  function automatic logic [7:0] rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 8'h00;
  endfunction

  // Byte memory with random wait states
  always @(negedge clk) begin
    if (bus.mem_read_en && !hold_mem) begin
      bus.mem_ready    = ($urandom_range(0, 3) != 0);
      bus.mem_data_out = rd(bus.mem_addr);
    end else begin
      bus.mem_ready    = 1'b0;
      bus.mem_data_out = 8'h00;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  // Present a fetch request; push its expected response once accepted
  task automatic issue_req(input logic [1:0] kind, input exp_t e);
    bit got = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_kind  = kind;
    for (int i = 0; i < 50 && !got; i++) begin
      #1;
      if (bus.req_ready) begin
        got = 1'b1;
        sb.push_back(e);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    if (!got) chk("req_accept_timeout", 32'd0, 32'd1);
  endtask

  // Wait for a response, compare against the scoreboard, hold it, then consume
  task automatic wait_resp(input int hold);
    bit   seen = 1'b0;
    exp_t e;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (bus.resp_valid) seen = 1'b1;
      else @(negedge clk);
    end
    if (!seen) begin
      chk("resp_timeout", 32'd0, 32'd1);
      return;
    end
    if (sb.size() == 0) begin
      chk("resp_unexpected", 32'd1, 32'd0);
      return;
    end
    e = sb.pop_front();
    chk("resp_data", bus.resp_data, e.data);
    chk("resp_pc", bus.resp_pc, e.pc);
    chk("resp_err", 32'(bus.resp_err), 32'(e.err));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("hold_valid", 32'(bus.resp_valid), 32'd1);
      chk("hold_data", bus.resp_data, e.data);
      chk("hold_err", 32'(bus.resp_err), 32'(e.err));
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    chk("resp_drop", 32'(bus.resp_valid), 32'd0);
  endtask

  // Place bytes at the current PC, fetch them and check the PC advance
  task automatic do_item(input logic [1:0] kind, input logic [47:0] bytes, input int nb,
                         input logic [31:0] data, input logic err, input int len,
                         input int hold);
    exp_t e;
    for (int j = 0; j < nb; j++) mem[tb_pc + 32'(j)] = bytes[8*j +: 8];
    e.data = data;
    e.pc   = tb_pc;
    e.err  = err;
    issue_req(kind, e);
    wait_resp(hold);
    tb_pc = tb_pc + 32'(len);
    chk("pc_after", bus.pc, tb_pc);
  endtask

  initial begin
    exp_t e;
    bit   done;

    vecs[0]  = '{2'd0, 48'h41,           1, 32'h0000_0041, 1'b0, 1};
    vecs[1]  = '{2'd1, 48'h268EE5,       3, 32'h0009_8765, 1'b0, 3};
    vecs[2]  = '{2'd2, 48'h7F,           1, 32'hFFFF_FFFF, 1'b0, 1};
    vecs[3]  = '{2'd2, 48'h78BBC0,       3, 32'hFFFE_1DC0, 1'b0, 3};
    vecs[4]  = '{2'd3, 48'h80,           1, 32'h0000_0080, 1'b0, 1};
    vecs[5]  = '{2'd1, 48'h00,           1, 32'h0000_0000, 1'b0, 1};
    vecs[6]  = '{2'd2, 48'h7F80,         2, 32'hFFFF_FF80, 1'b0, 2};
    vecs[7]  = '{2'd2, 48'h3F,           1, 32'h0000_003F, 1'b0, 1};
    vecs[8]  = '{2'd2, 48'h7F80808080,   5, 32'hF000_0000, 1'b0, 5};
    vecs[9]  = '{2'd1, 48'h8080808080,   5, 32'h0000_0000, 1'b1, 5};
    vecs[10] = '{2'd0, 48'hFF,           1, 32'h0000_00FF, 1'b0, 1};
    vecs[11] = '{2'd2, 48'hFFFFFFFFFF,   5, 32'hFFFF_FFFF, 1'b1, 5};

    rst_n            = 1'b0;
    bus.enable       = 1'b0;
    bus.start_pc     = 32'h34;
    bus.call_valid   = 1'b0;
    bus.call_func_id = 8'd0;
    bus.jump_valid   = 1'b0;
    bus.jump_addr    = 32'h0;
    bus.req_valid    = 1'b0;
    bus.req_kind     = 2'd0;
    bus.resp_ready   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state
    chk("rst_pc", bus.pc, 32'h0);
    chk("rst_mem_read_en", 32'(bus.mem_read_en), 32'd0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_call_done", 32'(bus.call_done), 32'd0);
    chk("rst_fn_addr", bus.fn_addr, 32'h0);
    bus.req_valid = 1'b1;
    #1 chk("idle_disabled_ready", 32'(bus.req_ready), 32'd0);
    bus.enable = 1'b1;
    #1 chk("start_cycle_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk("start_pc_loaded", bus.pc, 32'h34);
    tb_pc = 32'h34;

    // Vector table
    for (int i = 0; i < 12; i++)
      do_item(vecs[i].kind, vecs[i].bytes, vecs[i].nb, vecs[i].data,
              vecs[i].err, vecs[i].len, i % 3);

    // Overlong uleb with consumer stalling for 4 cycles
    do_item(2'd1, 48'h01FFFFFFFFFF, 6, 32'hFFFF_FFFF, 1'b1, 5, 4);

    // Simultaneous call/jump/req: only the call is taken; then table lookup
    mem[32'h1A] = 8'h00; mem[32'h1B] = 8'h01; mem[32'h1C] = 8'h00;
    mem[32'h1D] = 8'h00; mem[32'h1E] = 8'h0D;
    @(negedge clk);
    bus.call_valid   = 1'b1;
    bus.call_func_id = 8'd2;
    bus.jump_valid   = 1'b1;
    bus.jump_addr    = 32'hDEAD_BEEF;
    bus.req_valid    = 1'b1;
    bus.req_kind     = 2'd0;
    #1;
    chk("prio_call_ready", 32'(bus.call_ready), 32'd1);
    chk("prio_req_ready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.call_valid = 1'b0;
    bus.jump_valid = 1'b0;
    bus.req_valid  = 1'b0;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      if (bus.call_done) done = 1'b1;
      else @(negedge clk);
    end
    chk("call_done", 32'(done), 32'd1);
    chk("fn_addr", bus.fn_addr, 32'h100);
    chk("fn_argc", 32'(bus.fn_argc), 32'd3);
    chk("fn_is_import", 32'(bus.fn_is_import), 32'd0);
    chk("fn_is_service", 32'(bus.fn_is_service), 32'd1);
    chk("call_pc", bus.pc, 32'h100);
    @(negedge clk);
    chk("call_done_pulse", 32'(bus.call_done), 32'd0);
    chk("call_pc_held", bus.pc, 32'h100);
    tb_pc = 32'h100;
    do_item(2'd0, 48'hA7, 1, 32'h0000_00A7, 1'b0, 1, 0);

    // Jump to the top of the address space; uleb straddles the PC wrap
    @(negedge clk);
    bus.jump_valid = 1'b1;
    bus.jump_addr  = 32'hFFFF_FFFF;
    @(negedge clk);
    bus.jump_valid = 1'b0;
    chk("jump_pc", bus.pc, 32'hFFFF_FFFF);
    tb_pc = 32'hFFFF_FFFF;
    do_item(2'd1, 48'h0185, 2, 32'h0000_0085, 1'b0, 2, 1);

    // Enable drops while a fetch is stalled: it still completes, then no accepts
    mem[tb_pc] = 8'hE5; mem[tb_pc + 32'd1] = 8'h8E; mem[tb_pc + 32'd2] = 8'h26;
    hold_mem = 1'b1;
    e.data = 32'h0009_8765; e.pc = tb_pc; e.err = 1'b0;
    issue_req(2'd1, e);
    bus.enable = 1'b0;
    repeat (3) @(negedge clk);
    hold_mem = 1'b0;
    wait_resp(0);
    tb_pc = tb_pc + 32'd3;
    chk("disabled_pc", bus.pc, tb_pc);
    bus.req_valid = 1'b1;
    #1 chk("disabled_no_accept", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.enable    = 1'b1;

    // Reset while a LEB read is stalled on memory
    mem[tb_pc] = 8'h80; mem[tb_pc + 32'd1] = 8'h80;
    hold_mem = 1'b1;
    e.data = 32'h0; e.pc = tb_pc; e.err = 1'b0;
    issue_req(2'd1, e);
    @(negedge clk);
    chk("stalled_read_en", 32'(bus.mem_read_en), 32'd1);
    rst_n          = 1'b0;
    bus.req_valid  = 1'b1;
    bus.call_valid = 1'b1;
    @(negedge clk);
    sb.delete();
    chk("mid_rst_pc", bus.pc, 32'h0);
    chk("mid_rst_mem_read_en", 32'(bus.mem_read_en), 32'd0);
    chk("mid_rst_mem_addr", bus.mem_addr, 32'h0);
    chk("mid_rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("mid_rst_resp_data", bus.resp_data, 32'h0);
    chk("mid_rst_fn_addr", bus.fn_addr, 32'h0);
    chk("mid_rst_fn_argc", 32'(bus.fn_argc), 32'd0);
    #1;
    chk("mid_rst_call_ready", 32'(bus.call_ready), 32'd0);
    chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst_n          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.call_valid = 1'b0;
    hold_mem       = 1'b0;
    @(negedge clk);
    chk("restart_pc", bus.pc, 32'h34);
    repeat (2) @(negedge clk);
    chk("restart_idle_read_en", 32'(bus.mem_read_en), 32'd0);
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
